mt_remap_nw_1rw: RTL and testbench
==================================

MT_REMAP_NW_1RW -- requirements
Module: mt_remap_nw_1rw

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data word width.
REQ-002 SHALL have parameter NUMWRPT, default 2: write ports per cycle.
REQ-003 SHALL have parameter NUMVBNK / BITVBNK, default 4 / 2: virtual banks, power of two.
REQ-004 SHALL have parameter NUMVROW / BITVROW, default 256 / 8: rows per bank.
REQ-005 SHALL have parameter NUMPBNK / BITPBNK, default 6 / 3: physical 1rw banks; elaboration error unless NUMPBNK >= NUMVBNK+NUMWRPT.
REQ-006 SHALL have parameters NUMADDR = NUMVBNK*NUMVROW and BITADDR = BITVBNK+BITVROW.
REQ-007 SHALL have parameter SRAM_DELAY, default 1: physical bank read latency.
REQ-008 SHALL use one clock and a synchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, synchronous, active-high reset.
REQ-009 SHALL have ports write input NUMWRPT, wr_adr input NUMWRPT*BITADDR and din input NUMWRPT*WIDTH.
REQ-010 SHALL have ports read input 1 and rd_adr input BITADDR.
REQ-011 SHALL have ports rd_vld output 1 and rd_dout output WIDTH.
REQ-012 SHALL have port ready output 1: initialisation complete.
REQ-013 SHALL have port reloc_cnt output 16: saturating count of relocated writes.
REQ-014 SHALL have ports t1_readA output NUMPBNK, t1_writeA output NUMPBNK, t1_addrA output NUMPBNK*BITVROW and t1_dinA output NUMPBNK*WIDTH.
REQ-015 SHALL have port t1_doutA input NUMPBNK*WIDTH.

Function
REQ-016 SHALL decode each address as vbank = adr[BITVBNK-1:0] and row = adr[BITADDR-1:BITVBNK].
REQ-017 SHALL hold in flops a map table: per row, a NUMVBNK-entry vbank->pbank map whose entries are always pairwise distinct.
REQ-018 SHALL run an FSM with states INIT and READY; rst forces INIT with row counter 0.
REQ-019 SHALL, in INIT, write zero to row counter in all pbanks, load the identity map (vbank i->pbank i) for that row, and increment the counter.
REQ-020 SHALL go INIT->READY after row NUMVROW-1, so ready rises exactly NUMVROW cycles after rst deasserts.
REQ-021 SHALL ignore read/write while ready=0.
REQ-022 SHALL, on a read in READY, drive t1_readA of map[row][vbank] with t1_addrA=row; the read has priority on that pbank.
REQ-023 SHALL process writes in port order 0..NUMWRPT-1 within one cycle.
REQ-024 SHALL, for each write, use the home pbank map[row][vbank] if it is not busy (busy = claimed by the read or an earlier write this cycle).
REQ-025 SHALL otherwise relocate the write to the lowest-index pbank not in the row's current map (including same-cycle updates) and not busy, set map[row][vbank] to it, and increment reloc_cnt, saturating at 0xFFFF.
REQ-026 SHALL, when two writes hit the same address in one cycle, perform only the highest-numbered port; lower ports are dropped and not counted.
REQ-027 SHALL make map updates visible from the next cycle.
REQ-028 SHALL give read-before-write semantics: a read and a write to the same address in one cycle return the old data, because the write relocates off the read pbank.
REQ-029 SHALL assert rd_vld exactly SRAM_DELAY+1 cycles after an accepted read, with rd_dout from the registered pbank select; rd_dout is don't-care when rd_vld=0.
REQ-030 SHALL support back-to-back reads every cycle, with the pipeline depth fixed at SRAM_DELAY+1.

Reset
REQ-031 SHALL, in the cycle rst is high, force ready=0, rd_vld=0 (pipeline flushed), reloc_cnt=0, FSM=INIT and counter=0.
REQ-032 SHALL treat rst mid-operation (including mid-INIT) as restarting the full INIT sweep; no in-flight read returns.

Structure
REQ-033 SHALL have no shared package; address-split widths are local parameters.
REQ-034 SHALL use one sub-module, mt_remap_pick: combinational lowest-index free-and-not-busy pbank selector, instantiated per write port.

Verification (NUMVBNK=4, NUMWRPT=2, NUMPBNK=6, NUMVROW=8, WIDTH=16, SRAM_DELAY=1)
REQ-035 SHALL cover init: rst 1 cycle -> ready=0 for 8 cycles then 1; reading any address gives 0x0000 with rd_vld 2 cycles after read.
REQ-036 SHALL cover same-bank conflict: writes to adr 0x00=0xAAAA and adr 0x04=0xBBBB in one cycle -> port1 relocated to pbank 4, reloc_cnt=1; later reads return 0xAAAA and 0xBBBB.
REQ-037 SHALL cover read/write collision: read 0x05 with write 0x05=0x1234 in one cycle -> read returns the old value; next read returns 0x1234.
REQ-038 SHALL cover same-address writes: both ports write 0x03 (0x1111, 0x2222) -> read returns 0x2222 and reloc_cnt is unchanged.
REQ-039 SHALL cover reset mid-operation: rst during traffic -> rd_vld=0 next cycle, ready low for 8 cycles, and all data reads 0x0000 afterwards.
REQ-040 SHALL cover random soak: random reads/writes, checked against a reference model with no data mismatch, map entries per row always distinct, and saturation forced at 0xFFFF.

Source files
------------

// File: rtl/mt_remap_nw_1rw_if.sv
// rtl/mt_remap_nw_1rw_if.sv - host-side read/write port bundle for the remapped 1rw memory
interface mt_remap_nw_1rw_if #(
  parameter int WIDTH   = 32,
  parameter int NUMWRPT = 2,
  parameter int BITADDR = 10
);
  logic [NUMWRPT-1:0]         write;
  logic [NUMWRPT*BITADDR-1:0] wr_adr;
  logic [NUMWRPT*WIDTH-1:0]   din;
  logic                       read;
  logic [BITADDR-1:0]         rd_adr;
  logic                       rd_vld;
  logic [WIDTH-1:0]           rd_dout;

  modport master (output write, wr_adr, din, read, rd_adr, input rd_vld, rd_dout);
  modport slave  (input write, wr_adr, din, read, rd_adr, output rd_vld, rd_dout);
endinterface

// File: rtl/mt_remap_pick.sv
// rtl/mt_remap_pick.sv - lowest-index physical bank that is neither mapped nor busy
module mt_remap_pick #(
  parameter int NUMPBNK = 6,
  parameter int BITPBNK = 3
) (
  input  logic [NUMPBNK-1:0] used,
  output logic               found,
  output logic [BITPBNK-1:0] idx
);
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int p = NUMPBNK - 1; p >= 0; p--) begin
      if (!used[p]) begin
        found = 1'b1;
        idx   = BITPBNK'(p);
      end
    end
  end
endmodule

// File: rtl/mt_remap_nw_1rw.sv
// rtl/mt_remap_nw_1rw.sv - multi-write/one-read memory built from 1rw banks by relocating
// conflicting writes into spare physical banks through a per-row vbank->pbank map.
module mt_remap_nw_1rw #(
  parameter int WIDTH      = 32,
  parameter int NUMWRPT    = 2,
  parameter int NUMVBNK    = 4,
  parameter int BITVBNK    = 2,
  parameter int NUMVROW    = 256,
  parameter int BITVROW    = 8,
  parameter int NUMPBNK    = 6,
  parameter int BITPBNK    = 3,
  parameter int NUMADDR    = NUMVBNK * NUMVROW,
  parameter int BITADDR    = BITVBNK + BITVROW,
  parameter int SRAM_DELAY = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  mt_remap_nw_1rw_if.slave            host,
  output logic                        ready,
  output logic [15:0]                 reloc_cnt,
  output logic [NUMPBNK-1:0]          t1_readA,
  output logic [NUMPBNK-1:0]          t1_writeA,
  output logic [NUMPBNK*BITVROW-1:0]  t1_addrA,
  output logic [NUMPBNK*WIDTH-1:0]    t1_dinA,
  input  logic [NUMPBNK*WIDTH-1:0]    t1_doutA
);
  if (NUMPBNK < NUMVBNK + NUMWRPT || NUMADDR != NUMVBNK * NUMVROW || SRAM_DELAY < 1) begin : g_bad_cfg
    $error("mt_remap_nw_1rw: illegal parameter combination");
  end

  typedef enum logic {ST_INIT, ST_READY} state_e;

  state_e               state_q, state_d;
  logic [BITVROW-1:0]   cnt_q, cnt_d;
  logic [15:0]          reloc_q, reloc_d;
  logic [BITPBNK-1:0]   map_q [NUMVROW][NUMVBNK];
  logic [BITPBNK-1:0]   map_d [NUMVROW][NUMVBNK];
  logic [SRAM_DELAY:0]  vld_q, vld_d;
  logic [BITPBNK-1:0]   sel_q [SRAM_DELAY];
  logic [BITPBNK-1:0]   sel_d [SRAM_DELAY];
  logic [WIDTH-1:0]     dout_q, dout_d;

  logic                 rd_ok;
  logic [BITVROW-1:0]   rd_row;
  logic [BITVBNK-1:0]   rd_vb;
  logic [BITPBNK-1:0]   rd_pb;
  logic [NUMPBNK-1:0]   rd_busy;
  logic [NUMWRPT-1:0]   wr_act, reloc_v;
  logic [16:0]          rsum;

  assign ready     = (state_q == ST_READY) && !rst;
  assign reloc_cnt = rst ? 16'h0 : reloc_q;
  assign rd_ok     = host.read && ready;
  assign rd_row    = host.rd_adr[BITADDR-1:BITVBNK];
  assign rd_vb     = host.rd_adr[BITVBNK-1:0];
  assign rd_pb     = map_q[rd_row][rd_vb];
  assign rd_busy   = rd_ok ? (NUMPBNK'(1) << rd_pb) : '0;

  // A write is dropped when a higher-numbered port targets the same address this cycle.
  always_comb begin
    for (int i = 0; i < NUMWRPT; i++) begin
      wr_act[i] = host.write[i] && ready;
      for (int j = i + 1; j < NUMWRPT; j++) begin
        if (host.write[j] && host.wr_adr[j*BITADDR +: BITADDR] == host.wr_adr[i*BITADDR +: BITADDR])
          wr_act[i] = 1'b0;
      end
    end
  end

  // Each port sees the read claim plus every earlier port's bank claim and map update.
  for (genvar i = 0; i < NUMWRPT; i++) begin : g_wr
    logic [NUMPBNK-1:0]              busy_in, busy_out, used;
    logic [NUMWRPT-1:0]              uv_in, uv_out;
    logic [NUMWRPT-1:0][BITVROW-1:0] ur_in, ur_out;
    logic [NUMWRPT-1:0][BITVBNK-1:0] ub_in, ub_out;
    logic [NUMWRPT-1:0][BITPBNK-1:0] up_in, up_out;
    logic [BITPBNK-1:0]              cur [NUMVBNK];
    logic [BITVROW-1:0]              row;
    logic [BITVBNK-1:0]              vb;
    logic [BITPBNK-1:0]              home, pick, bank;
    logic                            found, done;

    assign row = host.wr_adr[i*BITADDR+BITVBNK +: BITVROW];
    assign vb  = host.wr_adr[i*BITADDR +: BITVBNK];

    if (i == 0) begin : g_head
      assign busy_in = rd_busy;
      assign uv_in   = '0;
      assign ur_in   = '0;
      assign ub_in   = '0;
      assign up_in   = '0;
    end else begin : g_link
      assign busy_in = g_wr[i-1].busy_out;
      assign uv_in   = g_wr[i-1].uv_out;
      assign ur_in   = g_wr[i-1].ur_out;
      assign ub_in   = g_wr[i-1].ub_out;
      assign up_in   = g_wr[i-1].up_out;
    end

    always_comb begin
      for (int k = 0; k < NUMVBNK; k++) cur[k] = map_q[row][k];
      for (int j = 0; j < NUMWRPT; j++) begin
        if (uv_in[j] && ur_in[j] == row) cur[ub_in[j]] = up_in[j];
      end
      used = busy_in;
      for (int k = 0; k < NUMVBNK; k++) used[cur[k]] = 1'b1;
    end

    mt_remap_pick #(.NUMPBNK(NUMPBNK), .BITPBNK(BITPBNK)) u_pick (
      .used  (used),
      .found (found),
      .idx   (pick)
    );

    assign home       = cur[vb];
    assign done       = wr_act[i] && (!busy_in[home] || found);
    assign reloc_v[i] = wr_act[i] && busy_in[home] && found;
    assign bank       = busy_in[home] ? pick : home;
    assign busy_out   = done ? (busy_in | (NUMPBNK'(1) << bank)) : busy_in;

    always_comb begin
      uv_out    = uv_in;
      ur_out    = ur_in;
      ub_out    = ub_in;
      up_out    = up_in;
      uv_out[i] = done;
      ur_out[i] = row;
      ub_out[i] = vb;
      up_out[i] = bank;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    reloc_d   = reloc_q;
    map_d     = map_q;
    t1_readA  = '0;
    t1_writeA = '0;
    t1_addrA  = '0;
    t1_dinA   = '0;
    rsum      = {1'b0, reloc_q};
    if (state_q == ST_INIT && !rst) begin
      t1_writeA = '1;
      t1_addrA  = {NUMPBNK{cnt_q}};
      for (int k = 0; k < NUMVBNK; k++) map_d[cnt_q][k] = BITPBNK'(k);
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == BITVROW'(NUMVROW - 1)) state_d = ST_READY;
    end else if (ready) begin
      if (rd_ok) begin
        t1_readA[rd_pb] = 1'b1;
        t1_addrA[int'(rd_pb)*BITVROW +: BITVROW] = rd_row;
      end
      for (int i = 0; i < NUMWRPT; i++) begin
        if (g_wr[NUMWRPT-1].uv_out[i]) begin
          t1_writeA[g_wr[NUMWRPT-1].up_out[i]] = 1'b1;
          t1_addrA[int'(g_wr[NUMWRPT-1].up_out[i])*BITVROW +: BITVROW] = g_wr[NUMWRPT-1].ur_out[i];
          t1_dinA[int'(g_wr[NUMWRPT-1].up_out[i])*WIDTH +: WIDTH] = host.din[i*WIDTH +: WIDTH];
          map_d[g_wr[NUMWRPT-1].ur_out[i]][g_wr[NUMWRPT-1].ub_out[i]] = g_wr[NUMWRPT-1].up_out[i];
        end
        rsum = rsum + 17'(reloc_v[i]);
      end
      reloc_d = rsum[16] ? 16'hFFFF : rsum[15:0];
    end
  end

  // Read return: valid shifts SRAM_DELAY+1 deep; data is captured once the bank output lands.
  always_comb begin
    vld_d    = {vld_q[SRAM_DELAY-1:0], rd_ok};
    sel_d[0] = rd_pb;
    for (int k = 1; k < SRAM_DELAY; k++) sel_d[k] = sel_q[k-1];
    dout_d   = t1_doutA[int'(sel_q[SRAM_DELAY-1])*WIDTH +: WIDTH];
  end

  assign host.rd_vld  = vld_q[SRAM_DELAY] && !rst;
  assign host.rd_dout = dout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      reloc_q <= '0;
      vld_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      reloc_q <= reloc_d;
      vld_q   <= vld_d;
    end
  end

  always_ff @(posedge clk) begin
    map_q  <= map_d;
    sel_q  <= sel_d;
    dout_q <= dout_d;
  end
endmodule

// File: tb/tb_mt_remap_nw_1rw.sv
// tb/tb_mt_remap_nw_1rw.sv - directed and soak bench for mt_remap_nw_1rw with 1rw bank models
module tb_mt_remap_nw_1rw;
  logic        clk = 1'b0;
  logic        rst;
  logic        ready;
  logic [15:0] reloc_cnt;
  logic [5:0]  t1_readA, t1_writeA;
  logic [23:0] t1_addrA;
  logic [95:0] t1_dinA, t1_doutA;

  logic [15:0] bmem [6][8];
  logic [15:0] bq [6];

  logic [15:0] mem_m [32];
  logic        pv0, pv1, tb_ready;
  logic [15:0] pd0, pd1;
  int          init_cnt;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  mt_remap_nw_1rw_if #(.WIDTH(16), .NUMWRPT(2), .BITADDR(5)) hif ();

  mt_remap_nw_1rw #(
    .WIDTH(16), .NUMWRPT(2), .NUMVBNK(4), .BITVBNK(2), .NUMVROW(8), .BITVROW(3),
    .NUMPBNK(6), .BITPBNK(3), .SRAM_DELAY(1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .host      (hif),
    .ready     (ready),
    .reloc_cnt (reloc_cnt),
    .t1_readA  (t1_readA),
    .t1_writeA (t1_writeA),
    .t1_addrA  (t1_addrA),
    .t1_dinA   (t1_dinA),
    .t1_doutA  (t1_doutA)
  );

  always_ff @(posedge clk) begin
    for (int p = 0; p < 6; p++) begin
      if (t1_writeA[p]) bmem[p][t1_addrA[p*3 +: 3]] <= t1_dinA[p*16 +: 16];
      if (t1_readA[p]) bq[p] <= bmem[p][t1_addrA[p*3 +: 3]];
    end
  end

  always_comb begin
    t1_doutA = '0;
    for (int p = 0; p < 6; p++) t1_doutA[p*16 +: 16] = bq[p];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic [4:0] ra,
                       input logic w0, input logic [4:0] a0, input logic [15:0] d0,
                       input logic w1, input logic [4:0] a1, input logic [15:0] d1);
    hif.read   = rd;
    hif.rd_adr = ra;
    hif.write  = {w1, w0};
    hif.wr_adr = {a1, a0};
    hif.din    = {d1, d0};
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 16'h0);
  endtask

  // Reference: flat memory with read-before-write and highest-port-wins on same address.
  task automatic tick();
    logic        r, nv;
    logic [15:0] nd;
    logic [4:0]  a0, a1;
    r  = rst;
    a0 = hif.wr_adr[4:0];
    a1 = hif.wr_adr[9:5];
    nv = hif.read && tb_ready && !r;
    nd = mem_m[hif.rd_adr];
    if (tb_ready && !r) begin
      if (hif.write[0] && !(hif.write[1] && a0 == a1)) mem_m[a0] = hif.din[15:0];
      if (hif.write[1]) mem_m[a1] = hif.din[31:16];
    end
    @(posedge clk);
    #1;
    pv1 = pv0; pd1 = pd0; pv0 = nv; pd0 = nd;
    if (r) begin
      pv0 = 1'b0; pv1 = 1'b0; tb_ready = 1'b0; init_cnt = 8;
      for (int a = 0; a < 32; a++) mem_m[a] = 16'h0;
    end else if (init_cnt > 0) begin
      init_cnt--;
      if (init_cnt == 0) tb_ready = 1'b1;
    end
    chk("ready", {31'b0, ready}, {31'b0, tb_ready && !rst});
    chk("rd_vld", {31'b0, hif.rd_vld}, {31'b0, pv1 && !rst});
    if (pv1 && !rst) chk("rd_dout", {16'b0, hif.rd_dout}, {16'b0, pd1});
  endtask

  initial begin
    int bad;
    logic [4:0] ra;
    pv0 = 1'b0; pv1 = 1'b0; pd0 = '0; pd1 = '0; tb_ready = 1'b0; init_cnt = 0;
    for (int a = 0; a < 32; a++) mem_m[a] = 16'h0;
    rst = 1'b1;
    idle();
    tick();
    tick();
    chk("reset_reloc", {16'b0, reloc_cnt}, 32'h0);
    rst = 1'b0;

    // Traffic during the init sweep must be ignored.
    drive(1'b1, 5'h00, 1'b1, 5'h00, 16'hDEAD, 1'b0, 5'd0, 16'h0);
    for (int c = 0; c < 8; c++) tick();
    chk("ready_after_init", {31'b0, ready}, 32'h1);

    drive(1'b1, 5'h00, 1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 16'h0); tick();
    drive(1'b1, 5'h1F, 1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 16'h0); tick();
    drive(1'b1, 5'h0A, 1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 16'h0); tick();
    idle(); tick(); tick();

    drive(1'b0, 5'd0, 1'b1, 5'h00, 16'hAAAA, 1'b1, 5'h04, 16'hBBBB);
    #1;
    chk("conflict_wr_mask", {26'b0, t1_writeA}, 32'h11);
    tick();
    chk("conflict_reloc", {16'b0, reloc_cnt}, 32'h1);
    drive(1'b1, 5'h00, 1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 16'h0); tick();
    drive(1'b1, 5'h04, 1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 16'h0); tick();
    idle(); tick(); tick();

    drive(1'b1, 5'h05, 1'b1, 5'h05, 16'h1234, 1'b0, 5'd0, 16'h0);
    #1;
    chk("collide_rd_mask", {26'b0, t1_readA}, 32'h02);
    chk("collide_wr_mask", {26'b0, t1_writeA}, 32'h01);
    tick();
    drive(1'b1, 5'h05, 1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 16'h0); tick();
    idle(); tick(); tick();
    chk("collide_reloc", {16'b0, reloc_cnt}, 32'h2);

    drive(1'b0, 5'd0, 1'b1, 5'h03, 16'h1111, 1'b1, 5'h03, 16'h2222); tick();
    chk("same_adr_reloc", {16'b0, reloc_cnt}, 32'h2);
    drive(1'b1, 5'h03, 1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 16'h0); tick();
    idle(); tick(); tick();

    for (int c = 0; c < 1500; c++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 16'($urandom),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 16'($urandom));
      tick();
    end
    // Reading and writing the same address every cycle forces at least one relocation per cycle.
    for (int c = 0; c < 65540; c++) begin
      ra = 5'($urandom_range(0, 31));
      drive(1'b1, ra, 1'b1, 5'($urandom_range(0, 31)), 16'($urandom), 1'b1, ra, 16'($urandom));
      tick();
    end
    idle(); tick(); tick();
    chk("reloc_saturate", {16'b0, reloc_cnt}, 32'hFFFF);
    bad = 0;
    for (int r = 0; r < 8; r++)
      for (int i = 0; i < 4; i++)
        for (int j = i + 1; j < 4; j++)
          if (dut.map_q[r][i] == dut.map_q[r][j]) bad++;
    chk("map_distinct", 32'(bad), 32'h0);
    for (int a = 0; a < 32; a++) begin
      drive(1'b1, 5'(a), 1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 16'h0);
      tick();
    end
    idle(); tick(); tick();

    drive(1'b1, 5'h05, 1'b1, 5'h0A, 16'h5555, 1'b0, 5'd0, 16'h0); tick();
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_flush_vld", {31'b0, hif.rd_vld}, 32'h0);
    chk("rst_reloc", {16'b0, reloc_cnt}, 32'h0);
    for (int c = 0; c < 8; c++) tick();
    chk("ready_after_reinit", {31'b0, ready}, 32'h1);
    drive(1'b1, 5'h05, 1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 16'h0); tick();
    drive(1'b1, 5'h0A, 1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 16'h0); tick();
    drive(1'b1, 5'h00, 1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 16'h0); tick();
    drive(1'b1, 5'h03, 1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 16'h0); tick();
    idle(); tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
